// File: rtl/lt24_pio_in_capture.sv
// rtl/lt24_pio_in_capture.sv - Avalon-MM input PIO with sync, sticky edge capture and maskable irq
// Optional per-bit debounce filter enabled by defining LT24_PIO_IN_DEBOUNCE_EN.
module lt24_pio_in_capture #(
    parameter int WIDTH           = 1,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] d_prev;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr;
    logic [1:0]       arm_cnt;
    logic             armed;
    logic             wr_en;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign armed        = (arm_cnt == 2'd3);
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1      <= '0;
            s2      <= '0;
            d_prev  <= '0;
            arm_cnt <= 2'd0;
        end else begin
            s1      <= in_port;
            s2      <= s1;
            d_prev  <= d;
            if (!armed) begin
                arm_cnt <= arm_cnt + 2'd1;
            end
        end
    end

`ifdef LT24_PIO_IN_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] db_cnt [WIDTH];

    // d only follows s2 after it has disagreed for DEBOUNCE_CYCLES consecutive clocks
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s2[i] != d[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        d[i]      <= s2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + CW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end
`else
    logic unused_debounce;

    assign d               = s2;
    assign unused_debounce = ^DEBOUNCE_CYCLES;
`endif

    assign rise = d & ~d_prev;
    assign fall = ~d & d_prev;

    always_comb begin
        edge_det = rise | fall;
        case (EDGE_TYPE)
            0:       edge_det = rise;
            1:       edge_det = fall;
            default: edge_det = rise | fall;
        endcase
    end

    assign clr = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : '0;

    // a new edge in the same cycle as its write-1-to-clear keeps the bit set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture <= '0;
            irq_mask     <= '0;
        end else begin
            edge_capture <= (edge_capture & ~clr) | (armed ? edge_det : '0);
            if (wr_en && address == 2'd1) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = d;
            2'd1:    readdata[WIDTH-1:0] = irq_mask;
            2'd2:    readdata[WIDTH-1:0] = edge_capture;
            default: readdata = '0;
        endcase
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_lt24_pio_in_capture.sv
// tb/tb_lt24_pio_in_capture.sv - self-checking bench for lt24_pio_in_capture (1-bit rising and 4-bit any-edge instances)
module tb_lt24_pio_in_capture;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [0:0]  in_a;
    logic [3:0]  in_b;
    logic [31:0] rd_a;
    logic [31:0] rd_b;
    logic        irq_a;
    logic        irq_b;

    int total = 0;
    int bad   = 0;

    // reference: per instance, history of sampled inputs (p[0] newest), capture and mask
    int          t;
    logic [31:0] p [2][3];
    logic [31:0] cap [2];
    logic [31:0] msk [2];

    always #5 clk = ~clk;

    lt24_pio_in_capture #(.WIDTH(1), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_a),
        .readdata(rd_a), .irq(irq_a)
    );

    lt24_pio_in_capture #(.WIDTH(4), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(16)) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_b),
        .readdata(rd_b), .irq(irq_b)
    );

    function automatic logic [31:0] wm(input int j);
        return (j == 0) ? 32'h1 : 32'hF;
    endfunction

    function automatic int et(input int j);
        return (j == 0) ? 0 : 2;
    endfunction

    function automatic logic [31:0] edg(input int e, input logic [31:0] cur, input logic [31:0] prv);
        logic [31:0] r;
        logic [31:0] f;
        r = cur & ~prv;
        f = ~cur & prv;
        case (e)
            0:       return r;
            1:       return f;
            default: return r | f;
        endcase
    endfunction

    function automatic logic [31:0] exp_rd(input int j, input int a);
        case (a)
            0:       return p[j][1];
            1:       return msk[j];
            2:       return cap[j];
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        t = 0;
        for (int j = 0; j < 2; j++) begin
            for (int k = 0; k < 3; k++) p[j][k] = 32'h0;
            cap[j] = 32'h0;
            msk[j] = 32'h0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one clock edge: update the reference with the bus/inputs as currently driven
    task automatic tick();
        logic [31:0] set;
        logic [31:0] inj;
        t++;
        for (int j = 0; j < 2; j++) begin
            set = (t >= 4) ? (edg(et(j), p[j][1], p[j][2]) & wm(j)) : 32'h0;
            if (chipselect && !write_n) begin
                if (address == 2'd1) msk[j] = writedata & wm(j);
                if (address == 2'd2) cap[j] = cap[j] & ~writedata;
            end
            cap[j] = cap[j] | set;
            inj = (j == 0) ? {31'b0, in_a} : {28'b0, in_b};
            p[j][2] = p[j][1];
            p[j][1] = p[j][0];
            p[j][0] = inj;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1;
            chk($sformatf("%s_a_addr%0d", tag, a), rd_a, exp_rd(0, a));
            chk($sformatf("%s_b_addr%0d", tag, a), rd_b, exp_rd(1, a));
        end
        chk({tag, "_irq_a"}, {31'b0, irq_a}, {31'b0, |(cap[0] & msk[0])});
        chk({tag, "_irq_b"}, {31'b0, irq_b}, {31'b0, |(cap[1] & msk[1])});
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] dt);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = dt;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
    endtask

    task automatic cyc(input int n, input string tag);
        repeat (n) begin
            tick();
            check_all(tag);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = 32'h0;
        in_b       = 4'h0;
        model_reset();
`ifdef LT24_PIO_IN_DEBOUNCE_EN
        in_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        wr(2'd1, 32'h1);
        repeat (5) tick();
        in_a = 1'b1;
        repeat (10) tick();
        in_a = 1'b0;
        repeat (30) begin
            tick();
            address = 2'd0;
            #1;
            chk("glitch_data", rd_a, 32'h0);
            address = 2'd2;
            #1;
            chk("glitch_cap", rd_a, 32'h0);
        end
        in_a = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            tick();
            address = 2'd2;
            #1;
            chk($sformatf("pulse_cap_%0d", n), rd_a, (n >= 19) ? 32'h1 : 32'h0);
            chk($sformatf("pulse_irq_%0d", n), {31'b0, irq_a}, (n >= 19) ? 32'h1 : 32'h0);
        end
        in_a = 1'b0;
`else
        in_a = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset_n = 1'b1;

        // line held high through reset must not capture
        cyc(20, "held_high");
        address = 2'd0;
        #1;
        chk("held_high_data", rd_a, 32'h1);

        // masked rising edge: irq two edges after sampling, then W1C
        wr(2'd1, 32'h1);
        check_all("mask_wr");
        in_a = 1'b0;
        cyc(4, "fall_ignored");
        in_a = 1'b1;
        cyc(3, "rise");
        chk("rise_irq", {31'b0, irq_a}, 32'h1);
        wr(2'd2, 32'h1);
        check_all("w1c");

        // capture without mask, then enabling the mask raises irq at once
        wr(2'd1, 32'h0);
        in_a = 1'b0;
        cyc(3, "nomask_low");
        in_a = 1'b1;
        cyc(4, "nomask_rise");
        wr(2'd1, 32'h1);
        check_all("late_mask");
        chk("late_mask_irq", {31'b0, irq_a}, 32'h1);

        // clear lands on the same edge as a new capture
        wr(2'd2, 32'h1);
        check_all("pre_collide");
        in_a = 1'b0;
        cyc(3, "collide_low");
        in_a = 1'b1;
        tick();
        tick();
        wr(2'd2, 32'h1);
        check_all("set_wins");
        address = 2'd2;
        #1;
        chk("set_wins_cap", rd_a, 32'h1);

        // any-edge 4-bit instance
        wr(2'd1, 32'hF);
        in_b = 4'h5;
        cyc(3, "b_0to5");
        in_b = 4'h4;
        cyc(3, "b_5to4");
        address = 2'd2;
        #1;
        chk("b_cap5", rd_b, 32'h5);
        wr(2'd2, 32'h4);
        check_all("b_w1c4");
        wr(2'd0, 32'hFFFF_FFFF);
        check_all("b_wr_addr0");
        wr(2'd3, 32'hFFFF_FFFF);
        check_all("b_wr_addr3");

        // randomized inputs and bus writes
        repeat (300) begin
            in_a = 1'($urandom);
            in_b = 4'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                chipselect = 1'($urandom);
                write_n    = ($urandom_range(0, 3) == 0);
                address    = 2'($urandom);
                writedata  = $urandom;
                tick();
                chipselect = 1'b0;
                write_n    = 1'b1;
                writedata  = 32'h0;
            end else begin
                tick();
            end
            check_all("rand");
        end

        // asynchronous reset mid-operation
        wr(2'd1, 32'hF);
        in_b = 4'h0;
        cyc(3, "pre_rst_low");
        in_b = 4'hF;
        cyc(3, "pre_rst_high");
        chk("pre_rst_irq_b", {31'b0, irq_b}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_irq_a", {31'b0, irq_a}, 32'h0);
        chk("async_rst_irq_b", {31'b0, irq_b}, 32'h0);
        model_reset();
        check_all("in_reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc(6, "post_reset");
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
